// File: rtl/ama_riscv_rf_wb_sched.sv
// ama_riscv_rf_wb_sched
//
// Write-port scheduler in front of ama_riscv_reg_file. The register file has a
// single write port, which is shared here between the pipeline writeback stage
// and an auxiliary long-latency source (multi-cycle unit or debug).
//
// The pipeline has priority in normal operation. The aux source uses a
// valid/ready handshake. If aux is blocked long enough, the scheduler forces a
// one-cycle aux grant and stalls the pipeline so the pipe write is re-presented.
// After reset an optional sweep writes zero to x1..x31.
//
// Parameters
//   MAX_WAIT  blocked cycles tolerated before a forced aux grant (1..255)
//   INIT_EN   1: zero-fill x1..x31 after reset, 0: go straight to normal run
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pipe_we/addr/data        pipeline writeback request
//   aux_valid/addr/data      aux write request, aux_ready accepts it
//   rf_we/addr_d/data_d      register file write port
//   stall_pipe               pipeline must hold and re-present its writeback
//   init_done                registered, high once normal run is entered

module ama_riscv_rf_wb_sched #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned INIT_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_addr,
  input  logic [31:0] aux_data,
  output logic        rf_we,
  output logic [4:0]  rf_addr_d,
  output logic [31:0] rf_data_d,
  output logic        stall_pipe,
  output logic        init_done
);

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StForce
  } state_e;

  localparam state_e     StAfterReset = (INIT_EN != 0) ? StInit : StRun;
  localparam logic [7:0] WaitLast     = 8'(MAX_WAIT - 1);
  localparam logic [4:0] LastIdx      = 5'd31;

  state_e      state_q, state_d;
  logic [4:0]  init_idx_q, init_idx_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        init_done_q, init_done_d;

  logic        pipe_wr;
  logic        aux_wr;

  // Writes to x0 are dropped, so a pipe x0 writeback does not occupy the port.
  assign pipe_wr = pipe_we && (pipe_addr != 5'd0);
  assign aux_wr  = aux_valid && (aux_addr != 5'd0);

  always_comb begin
    rf_we       = 1'b0;
    rf_addr_d   = 5'd0;
    rf_data_d   = 32'd0;
    aux_ready   = 1'b0;
    stall_pipe  = 1'b0;
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      StInit: begin
        rf_we      = 1'b1;
        rf_addr_d  = init_idx_q;
        stall_pipe = 1'b1;
        wait_cnt_d = 8'd0;
        if (init_idx_q == LastIdx) begin
          state_d = StRun;
        end else begin
          init_idx_d = init_idx_q + 5'd1;
        end
      end

      StRun: begin
        if (pipe_wr) begin
          rf_we     = 1'b1;
          rf_addr_d = pipe_addr;
          rf_data_d = pipe_data;
        end else if (aux_valid) begin
          aux_ready = 1'b1;
          rf_we     = aux_wr;
          rf_addr_d = aux_addr;
          rf_data_d = aux_data;
        end

        // aux is only ever blocked in this state by an effective pipe write
        if (aux_valid && pipe_wr) begin
          if (wait_cnt_q == WaitLast) begin
            state_d    = StForce;
            wait_cnt_d = 8'd0;
          end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else if (aux_valid) begin
          wait_cnt_d = 8'd0;
        end
      end

      StForce: begin
        // Pipe inputs are ignored; the stall makes the pipe re-present next cycle.
        stall_pipe = 1'b1;
        aux_ready  = 1'b1;
        rf_we      = aux_wr;
        rf_addr_d  = aux_addr;
        rf_data_d  = aux_data;
        wait_cnt_d = 8'd0;
        state_d    = StRun;
      end

      default: begin
        state_d = StRun;
      end
    endcase

    init_done_d = init_done_q || (state_d == StRun);

    // Reset overrides everything, including a pending forced grant.
    if (rst) begin
      rf_we      = 1'b0;
      rf_addr_d  = 5'd0;
      rf_data_d  = 32'd0;
      aux_ready  = 1'b0;
      stall_pipe = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAfterReset;
      init_idx_q  <= 5'd1;
      wait_cnt_q  <= 8'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_ama_riscv_rf_wb_sched.sv
// Directed bench for ama_riscv_rf_wb_sched (MAX_WAIT=4, INIT_EN=1). A shadow
// register file captures the write port so written contents can be checked.

module tb_ama_riscv_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;
  logic        stall_pipe;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] shadow [32];
  logic [31:0] snap [32];
  int          x0_writes = 0;

  ama_riscv_rf_wb_sched #(
    .MAX_WAIT (4),
    .INIT_EN  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_addr   (aux_addr),
    .aux_data   (aux_data),
    .rf_we      (rf_we),
    .rf_addr_d  (rf_addr_d),
    .rf_data_d  (rf_data_d),
    .stall_pipe (stall_pipe),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  // Contents start as all-ones on reset so the zero-fill is observable.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) shadow[k] <= 32'hFFFF_FFFF;
    end else if (rf_we) begin
      shadow[rf_addr_d] <= rf_data_d;
      if (rf_addr_d == 5'd0) x0_writes <= x0_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_addr", 32'(rf_addr_d), 32'd0);
    chk("rst_rf_data", rf_data_d, 32'd0);
    chk("rst_aux_ready", 32'(aux_ready), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd1);
  endtask

  // Checks INIT writing idx first..last, leaving the bench in the next cycle.
  task automatic sweep(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      chk("init_we", 32'(rf_we), 32'd1);
      chk("init_addr", 32'(rf_addr_d), 32'(i));
      chk("init_data", rf_data_d, 32'd0);
      chk("init_stall", 32'(stall_pipe), 32'd1);
      chk("init_done_low", 32'(init_done), 32'd0);
      next();
    end
  endtask

  task automatic chk_zeroed();
    chk("init_done_high", 32'(init_done), 32'd1);
    chk("post_init_we", 32'(rf_we), 32'd0);
    chk("post_init_stall", 32'(stall_pipe), 32'd0);
    for (int r = 1; r < 32; r++) chk("zero_fill", shadow[r], 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    pipe_we   = 1'b0;
    pipe_addr = 5'd0;
    pipe_data = 32'd0;
    aux_valid = 1'b1;
    aux_addr  = 5'd3;
    aux_data  = 32'h0000_0033;

    // Reset held 3 cycles with an aux request pending.
    repeat (3) begin
      next();
      chk_reset_outs();
      chk("rst_init_done", 32'(init_done), 32'd0);
    end
    aux_valid = 1'b0;
    rst       = 1'b0;
    #1;

    // Full init sweep: 31 writes then RUN.
    sweep(1, 31);
    chk_zeroed();

    // Pipe wins over simultaneous aux.
    pipe_we   = 1'b1;
    pipe_addr = 5'd5;
    pipe_data = 32'hDEAD_BEEF;
    aux_valid = 1'b1;
    aux_addr  = 5'd6;
    aux_data  = 32'h1234_5678;
    #1;
    chk("prio_we", 32'(rf_we), 32'd1);
    chk("prio_addr", 32'(rf_addr_d), 32'd5);
    chk("prio_data", rf_data_d, 32'hDEAD_BEEF);
    chk("prio_aux_ready", 32'(aux_ready), 32'd0);
    chk("prio_stall", 32'(stall_pipe), 32'd0);
    next();
    pipe_we = 1'b0;
    #1;
    chk("aux_ready", 32'(aux_ready), 32'd1);
    chk("aux_addr", 32'(rf_addr_d), 32'd6);
    chk("aux_we", 32'(rf_we), 32'd1);
    next();
    aux_valid = 1'b0;
    #1;
    chk("x5", shadow[5], 32'hDEAD_BEEF);
    chk("x6", shadow[6], 32'h1234_5678);

    // Starvation: pipe writes x1..x4 back-to-back, aux forced on the 5th cycle.
    aux_valid = 1'b1;
    aux_addr  = 5'd7;
    aux_data  = 32'hCAFE_F00D;
    pipe_we   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pipe_addr = 5'(k + 1);
      pipe_data = 32'(k + 100);
      #1;
      chk("starve_blocked", 32'(aux_ready), 32'd0);
      chk("starve_nostall", 32'(stall_pipe), 32'd0);
      chk("starve_pipe_addr", 32'(rf_addr_d), 32'(k + 1));
      next();
    end
    pipe_addr = 5'd1;
    pipe_data = 32'h55;
    #1;
    chk("force_stall", 32'(stall_pipe), 32'd1);
    chk("force_ready", 32'(aux_ready), 32'd1);
    chk("force_we", 32'(rf_we), 32'd1);
    chk("force_addr", 32'(rf_addr_d), 32'd7);
    chk("force_data", rf_data_d, 32'hCAFE_F00D);
    next();
    aux_valid = 1'b0;
    #1;
    chk("after_force_stall", 32'(stall_pipe), 32'd0);
    chk("after_force_addr", 32'(rf_addr_d), 32'd1);
    chk("after_force_data", rf_data_d, 32'h55);
    next();
    pipe_we = 1'b0;
    #1;
    chk("x7", shadow[7], 32'hCAFE_F00D);
    chk("x4", shadow[4], 32'd103);
    chk("x1", shadow[1], 32'h55);

    // x0: aux blocked twice, then pipe x0 lets aux x0 handshake with no write.
    aux_valid = 1'b1;
    aux_addr  = 5'd0;
    aux_data  = 32'h2222;
    pipe_we   = 1'b1;
    pipe_addr = 5'd9;
    pipe_data = 32'h9;
    #1;
    next();
    next();
    pipe_addr = 5'd0;
    pipe_data = 32'h1111;
    #1;
    chk("x0_we", 32'(rf_we), 32'd0);
    chk("x0_ready", 32'(aux_ready), 32'd1);
    chk("x0_stall", 32'(stall_pipe), 32'd0);
    next();

    // Counter must have cleared: a fresh request is blocked a full 4 cycles.
    aux_addr = 5'd8;
    aux_data = 32'h88;
    for (int k = 0; k < 4; k++) begin
      pipe_addr = 5'(10 + k);
      pipe_data = 32'(k);
      #1;
      chk("clr_blocked", 32'(aux_ready), 32'd0);
      next();
    end
    #1;
    chk("clr_force_ready", 32'(aux_ready), 32'd1);
    chk("clr_force_addr", 32'(rf_addr_d), 32'd8);
    next();
    aux_valid = 1'b0;
    pipe_we   = 1'b0;
    #1;
    chk("x8", shadow[8], 32'h88);
    chk("x0_never_written", 32'(x0_writes), 32'd0);

    // Idle: no requests for 10 cycles, contents unchanged.
    for (int r = 0; r < 32; r++) snap[r] = shadow[r];
    for (int k = 0; k < 10; k++) begin
      chk("idle_we", 32'(rf_we), 32'd0);
      chk("idle_stall", 32'(stall_pipe), 32'd0);
      chk("idle_ready", 32'(aux_ready), 32'd0);
      next();
    end
    for (int r = 1; r < 32; r++) chk("idle_keep", shadow[r], snap[r]);

    // Reset, then reset again mid-INIT after x12 is written; sweep restarts.
    rst = 1'b1;
    #1;
    chk_reset_outs();
    next();
    chk("reinit_done_low", 32'(init_done), 32'd0);
    rst = 1'b0;
    #1;
    sweep(1, 12);
    rst       = 1'b1;
    aux_valid = 1'b1;
    #1;
    chk_reset_outs();
    next();
    aux_valid = 1'b0;
    rst       = 1'b0;
    #1;
    sweep(1, 31);
    chk_zeroed();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ama_riscv_rf_wb_sched.md
Name: ama_riscv_rf_wb_sched

Overview:
- Write-port scheduler in front of ama_riscv_reg_file, which has a single write port (we/addr_d/data_d).
- Shares that port between the pipeline writeback stage and an auxiliary long-latency source (multi-cycle unit or debug).
- Aux source uses a valid/ready handshake; the starvation bound for aux is enforced by stalling the pipeline.
- Optional post-reset init sequence zeroes x1–x31 before normal operation.

Parameters:
- MAX_WAIT, 4: cycles aux may be blocked before a forced grant; legal range 1–255.
- INIT_EN, 1: 1 = run the x1–x31 zero-fill after reset; 0 = go straight to RUN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline writeback request
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline writeback data
- aux_valid  in  1  aux write request
- aux_ready  out  1  aux request accepted this cycle
- aux_addr  in  5  aux destination register
- aux_data  in  32  aux write data
- rf_we  out  1  to reg file we
- rf_addr_d  out  5  to reg file addr_d
- rf_data_d  out  32  to reg file data_d
- stall_pipe  out  1  pipeline must hold its writeback and re-present it next cycle
- init_done  out  1  registered; high once RUN is first entered

Behaviour:
- One clock (clk); synchronous active-high reset (rst). All state updates on posedge clk.
- Outputs are combinational from state plus current inputs; the reg file commits on the following edge.
- While rst=1:
  - rf_we=0, rf_addr_d=0, rf_data_d=0, aux_ready=0, stall_pipe=1, init_done=0.
  - At the edge: state := INIT (or RUN if INIT_EN=0), init_idx := 1, wait_cnt := 0.
- INIT:
  - rf_we=1, rf_addr_d=init_idx, rf_data_d=0, stall_pipe=1, aux_ready=0.
  - init_idx increments each edge.
  - On the edge that writes idx 31: state := RUN, init_done := 1.
  - The sequence takes exactly 31 cycles. init_idx is 5 bits and never wraps to 0.
- RUN, with effective pipe write pw = pipe_we && pipe_addr!=0:
  - pw=1: rf_* = pipe_*; aux_ready=0; stall_pipe=0.
  - pw=0 and aux_valid=1: aux_ready=1. rf_we = (aux_addr!=0); rf_addr_d/rf_data_d = aux_*. stall_pipe=0.
  - Neither: rf_we=0, rf_addr_d=0, rf_data_d=0.
- wait_cnt:
  - Increments on each edge with aux_valid && !aux_ready.
  - Clears on any aux handshake (aux_valid && aux_ready).
  - If it is blocked and wait_cnt==MAX_WAIT-1: state := FORCE_AUX, wait_cnt := 0.
  - Width is 8 bits and it saturates; it never wraps.
- FORCE_AUX (one cycle):
  - stall_pipe=1, aux_ready=1, rf_* = aux_* (rf_we gated by aux_addr!=0).
  - Pipe inputs are ignored; state := RUN next edge.
  - If aux_valid=0 here (protocol violation), rf_we=0, no handshake, and state still returns to RUN.
- Guarantee: a continuously valid aux request is accepted within MAX_WAIT+1 cycles of first assertion.
- Aux protocol:
  - aux_* must stay stable while aux_valid=1 and aux_ready=0.
  - A handshake is complete at the edge where both are high.
- x0: writes to x0 from either source never assert rf_we. An aux x0 request still handshakes.
- Simultaneous requests: the pipe wins in RUN; aux wins only in FORCE_AUX.
- Reset mid-INIT or mid-FORCE: rst takes priority; the sequence restarts at init_idx=1 and any pending aux grant is discarded (aux_ready=0).
- init_done never falls except under rst.

Test Plan:
- Init sweep: rst high 3 cycles, then low, INIT_EN=1 → rf_we=1 for exactly 31 cycles with rf_addr_d 1..31 and data 0; stall_pipe=1 throughout; init_done=1 on the 32nd cycle; reading x1–x31 via reg-file ports A/B returns 0.
- Pipe priority: pipe_we=1, pipe_addr=5, pipe_data=0xDEADBEEF together with aux_valid=1, aux_addr=6 → x5 written, aux_ready=0; next cycle with pipe idle → aux_ready=1 and x6 written.
- Starvation, MAX_WAIT=4: pipe writes x1..x4 back-to-back continuously with aux_valid=1 → aux blocked 4 cycles, 5th cycle stall_pipe=1, aux_ready=1, aux data written; stall_pipe=0 the following cycle.
- x0 handling: pipe_we=1, pipe_addr=0 with aux_valid=1, aux_addr=0 → rf_we=0, aux_ready=1, x0 reads 0; wait_cnt cleared.
- Reset mid-INIT: assert rst after rf_addr_d=12 → outputs go to reset values; after release the sweep restarts at 1 and runs the full 31 cycles.
- Idle/no-write: no requests for 10 cycles → rf_we=0, stall_pipe=0; reg file contents unchanged (read x1..x31 on A and B equal prior values).
